assoc_wb_cache: RTL and testbench
=================================

// Module: assoc_wb_cache
// PURPOSE
//  Parametrised N-way set-associative write-back, write-allocate cache with an LRU victim policy.
//  It sits between the processor data port (word address, 32-bit data, stall) and the 4-word-line memory port.
//  It replaces the fixed direct-mapped L1/L2 pair as the single configurable data-cache level.
//  It also exports saturating hit/miss counters for performance runs.
// PARAMETERS
//  ADDR_W     30  processor word-address width; bits [1:0] select the word within a 4-word line
//  NUM_SETS   8   number of sets; power of 2, >=2; IDX_W = log2(NUM_SETS)
//  NUM_WAYS   2   ways per set; 1, 2 or 4; AGE_W = max(1, log2(NUM_WAYS))
//  CNT_W      16  width of the hit and miss counters
// PORTS
//  clk          in   1          clock, rising edge
//  proc_reset   in   1          asynchronous, active-high reset
//  proc_read    in   1          processor read request
//  proc_write   in   1          processor write request
//  proc_addr    in   ADDR_W     word address: {tag, index[IDX_W], offset[2]}
//  proc_wdata   in   32         processor write data
//  proc_stall   out  1          request not complete; the processor holds all request inputs stable
//  proc_rdata   out  32         read data, valid while proc_read=1 and proc_stall=0
//  mem_read     out  1          line read request, registered
//  mem_write    out  1          line write-back request, registered
//  mem_addr     out  ADDR_W-2   line address {tag, index}, registered
//  mem_wdata    out  128        victim line, word0 in [31:0], registered
//  mem_rdata    in   128        refill line, word0 in [31:0]
//  mem_ready    in   1          one-cycle completion pulse, sampled on clk
//  hit_cnt      out  CNT_W      saturating count of first-look hits
//  miss_cnt     out  CNT_W      saturating count of misses
// BEHAVIOUR
//  Reset (asynchronous, immediate):
//   - all valid and dirty bits cleared; age of way w = w; FSM to COMPARE
//   - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0; hit_cnt=0, miss_cnt=0; retry flag=0
//   - any in-flight memory transaction is abandoned
//  Hit detection: a way hits when valid=1 and its tag equals the tag of proc_addr.
//  States: COMPARE, WRITEBACK, ALLOCATE.
//  COMPARE, no request: proc_stall=0.
//  COMPARE, hit:
//   - proc_stall=0 in the same cycle (combinational)
//   - read: proc_rdata = selected word
//   - write: word written and dirty set at the clock edge
//   - the hit way's age is updated (see LRU)
//   - hit_cnt increments unless the retry flag is set
//  COMPARE, miss:
//   - proc_stall=1 combinationally; miss_cnt increments; retry flag set
//   - victim = lowest-index invalid way, otherwise the way with age NUM_WAYS-1
//   - victim dirty: go to WRITEBACK with mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim line
//   - victim clean: go to ALLOCATE with mem_read=1, mem_addr={req tag, index}
//  WRITEBACK: stall=1; outputs held until mem_ready is sampled.
//   - Then mem_write=0, mem_read=1, mem_addr={req tag, index}; go to ALLOCATE.
//  ALLOCATE: stall=1; held until mem_ready is sampled.
//   - Then victim line = mem_rdata, valid=1, dirty=0, tag written; mem_read=0; go to COMPARE.
//  Retry: the next COMPARE cycle is a guaranteed hit and completes the request.
//   - That hit is not counted; the retry flag clears.
//   - A write miss therefore costs refill + 1 cycle and ends dirty.
//  Refill-to-hit latency: stall falls 1 cycle after the mem_ready edge.
//  mem_ready sampled in COMPARE is ignored.
//  mem_read and mem_write are never high together.
//  LRU, per set, on every hit or fill of way h:
//   - age[h] <= 0
//   - every way with age < old age[h] increments
//   - ages remain a permutation of 0..NUM_WAYS-1
//  NUM_WAYS=1: the victim is always way 0; no age state.
//  proc_read and proc_write both high: treated as a write.
//  Counters saturate at 2^CNT_W-1 and do not wrap.
//  Address arithmetic: tag width = ADDR_W-2-IDX_W; no other truncation.
// TESTING
//  1. After reset, read 0x000 -> mem_read=1, mem_addr=0; return 128'h4444_..._3333_..._2222_..._1111 with mem_ready after 3 cycles -> stall falls the next cycle, proc_rdata=word0, miss_cnt=1, hit_cnt=0.
//  2. Then read 0x002 -> proc_stall=0 in the same cycle, proc_rdata=word2, hit_cnt=1; no memory activity.
//  3. NUM_SETS=8, NUM_WAYS=2: fill set 0 with tags A, B; read A; read tag C -> way B is evicted (LRU); B clean -> no mem_write, only mem_read.
//  4. Write 0xDEADBEEF to tag A word1, then miss tags C and D -> mem_write precedes mem_read; mem_addr={A,0}; mem_wdata[63:32]=32'hDEADBEEF.
//  5. Assert proc_reset while mem_read=1 -> mem_read drops before the next edge; a later mem_ready is ignored; re-reading the address misses again.
//  6. CNT_W=4: 20 consecutive hits -> hit_cnt holds at 15.

Source files
------------

// File: rtl/assoc_wb_cache_if.sv
// Processor-side and memory-side handshake bundle for assoc_wb_cache.
// The slave modport is the cache; the master modport is the processor/memory environment.
interface assoc_wb_cache_if #(
    parameter int ADDR_W = 30
);
    logic              proc_read;
    logic              proc_write;
    logic [ADDR_W-1:0] proc_addr;
    logic [31:0]       proc_wdata;
    logic              proc_stall;
    logic [31:0]       proc_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-3:0] mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata,
        output proc_stall, proc_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata,
        input  proc_stall, proc_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/assoc_wb_cache.sv
// N-way set-associative write-back, write-allocate data cache with LRU replacement
// and saturating hit/miss counters; 4-word lines toward memory.
module assoc_wb_cache #(
    parameter int ADDR_W   = 30,
    parameter int NUM_SETS = 8,
    parameter int NUM_WAYS = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              proc_reset,
    assoc_wb_cache_if.slave   bus,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    localparam int AGE_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t             state_q;
    logic [127:0]       line_q  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]   tag_q   [NUM_SETS][NUM_WAYS];
    logic [AGE_W-1:0]   age_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [AGE_W-1:0]   victim_q;
    logic               retry_q;

    logic [1:0]         off;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               req;
    logic               hit;
    logic [AGE_W-1:0]   hit_way;
    logic [AGE_W-1:0]   victim;
    logic               found;
    logic               cmp_hit;
    logic               fill;
    logic               lru_en;
    logic [AGE_W-1:0]   lru_way;

    assign {tag, idx, off} = bus.proc_addr;
    assign req     = bus.proc_read | bus.proc_write;
    assign cmp_hit = (state_q == COMPARE) && req && hit;
    assign fill    = (state_q == ALLOCATE) && bus.mem_ready;
    assign lru_en  = cmp_hit | fill;
    assign lru_way = fill ? victim_q : hit_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    // Victim: first invalid way, else the oldest way of the set.
    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!found && !valid_q[idx][w]) begin
                found  = 1'b1;
                victim = AGE_W'(w);
            end
        end
        if (!found) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                if (age_q[idx][w] == AGE_W'(NUM_WAYS - 1)) victim = AGE_W'(w);
            end
        end
    end

    always_comb begin
        bus.proc_stall = (state_q != COMPARE) || (req && !hit);
        bus.proc_rdata = line_q[idx][hit_way][{off, 5'd0} +: 32];
    end

    always_ff @(posedge clk) begin
        if (cmp_hit && bus.proc_write) line_q[idx][hit_way][{off, 5'd0} +: 32] <= bus.proc_wdata;
        if (fill) begin
            line_q[idx][victim_q] <= bus.mem_rdata;
            tag_q[idx][victim_q]  <= tag;
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q       <= COMPARE;
            retry_q       <= 1'b0;
            victim_q      <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int unsigned w = 0; w < NUM_WAYS; w++) age_q[s][w] <= AGE_W'(w);
            end
        end else begin
            if (lru_en) begin
                for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                    if (AGE_W'(w) == lru_way) age_q[idx][w] <= '0;
                    else if (age_q[idx][w] < age_q[idx][lru_way]) age_q[idx][w] <= age_q[idx][w] + 1'b1;
                end
            end
            case (state_q)
                COMPARE: begin
                    if (req && hit) begin
                        if (bus.proc_write) dirty_q[idx][hit_way] <= 1'b1;
                        // The post-refill hit completes a request already counted as a miss.
                        if (retry_q) retry_q <= 1'b0;
                        else if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                    end else if (req) begin
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                        retry_q  <= 1'b1;
                        victim_q <= victim;
                        if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                            bus.mem_write <= 1'b1;
                            bus.mem_addr  <= {tag_q[idx][victim], idx};
                            bus.mem_wdata <= line_q[idx][victim];
                            state_q       <= WRITEBACK;
                        end else begin
                            bus.mem_read <= 1'b1;
                            bus.mem_addr <= {tag, idx};
                            state_q      <= ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ready) begin
                        bus.mem_write <= 1'b0;
                        bus.mem_read  <= 1'b1;
                        bus.mem_addr  <= {tag, idx};
                        state_q       <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        valid_q[idx][victim_q] <= 1'b1;
                        dirty_q[idx][victim_q] <= 1'b0;
                        bus.mem_read           <= 1'b0;
                        state_q                <= COMPARE;
                    end
                end
                default: state_q <= COMPARE;
            endcase
        end
    end
endmodule

// File: tb/tb_assoc_wb_cache.sv
// Scoreboard bench for assoc_wb_cache: a word-level reference memory supplies expected read
// data, a line-level backing store answers refills and absorbs write-backs.
module tb_assoc_wb_cache;
    logic       clk;
    logic       rst;
    logic [3:0] hit_cnt;
    logic [3:0] miss_cnt;

    assoc_wb_cache_if #(.ADDR_W(30)) bus();

    assoc_wb_cache #(.ADDR_W(30), .NUM_SETS(8), .NUM_WAYS(2), .CNT_W(4)) dut (
        .clk(clk), .proc_reset(rst), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    typedef struct {
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } mem_txn_t;

    mem_txn_t     mlog[$];
    logic [31:0]  exp_q[$];
    logic [127:0] mem_store [logic [27:0]];
    logic [31:0]  ref_words [logic [29:0]];
    int           passed = 0;
    int           total  = 0;
    int           both_hi = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    function automatic logic [31:0] init_word(input logic [27:0] la, input logic [1:0] i);
        if (la == 28'd0) return 32'h1111_1111 * (32'(i) + 32'd1);
        return {2'b00, la, i} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [127:0] line_of(input logic [27:0] la);
        if (mem_store.exists(la)) return mem_store[la];
        return {init_word(la, 2'd3), init_word(la, 2'd2), init_word(la, 2'd1), init_word(la, 2'd0)};
    endfunction

    function automatic logic [31:0] gold(input logic [29:0] a);
        if (ref_words.exists(a)) return ref_words[a];
        return init_word(a[29:2], a[1:0]);
    endfunction

    function automatic logic [29:0] mk(input int unsigned t, input int unsigned s, input int unsigned o);
        return {25'(t), 3'(s), 2'(o)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.proc_read = 1'b0; bus.proc_write = 1'b0; bus.proc_addr = '0; bus.proc_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        mlog.delete();
    endtask

    // One processor request; acts as the memory while the cache stalls.
    task automatic access(input logic do_rd, input logic do_wr, input logic [29:0] a,
                          input logic [31:0] wd, output int cyc);
        int          lat;
        bit          busy;
        bit          done;
        logic [31:0] exp;
        @(negedge clk);
        mlog.delete();
        bus.proc_read = do_rd; bus.proc_write = do_wr; bus.proc_addr = a; bus.proc_wdata = wd;
        if (do_wr) ref_words[a] = wd;
        else exp_q.push_back(gold(a));
        cyc = 0; lat = 0; busy = 1'b0; done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            #1;
            if (bus.mem_read && bus.mem_write) both_hi++;
            if (!bus.proc_stall) begin
                done = 1'b1;
                if (!do_wr) begin
                    exp = exp_q.pop_front();
                    total++;
                    if (bus.proc_rdata !== exp) $display("FAIL rdata addr=%h got=%h exp=%h", a, bus.proc_rdata, exp);
                    else passed++;
                end
            end else begin
                cyc++;
                if (bus.mem_read || bus.mem_write) begin
                    if (!busy) begin
                        busy = 1'b1; lat = 0;
                        mlog.push_back('{bus.mem_write, bus.mem_addr, bus.mem_wdata});
                    end
                    lat++;
                    if (lat == 3) begin
                        if (bus.mem_write) mem_store[bus.mem_addr] = bus.mem_wdata;
                        else bus.mem_rdata = line_of(bus.mem_addr);
                        bus.mem_ready = 1'b1;
                        busy = 1'b0;
                    end
                end
                @(negedge clk);
                bus.mem_ready = 1'b0;
            end
        end
        if (!done) begin
            total++;
            $display("FAIL timeout addr=%h got=stalled exp=complete", a);
            exp_q.delete();
        end else begin
            @(posedge clk);
            #1;
        end
        bus.proc_read = 1'b0; bus.proc_write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (bus.proc_stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", bus.proc_stall); else passed++;
        total++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) $display("FAIL reset_mem_rw got=%b%b exp=00", bus.mem_read, bus.mem_write); else passed++;
        total++; if (bus.mem_addr !== 28'd0 || bus.mem_wdata !== 128'd0) $display("FAIL reset_mem_bus got=%h/%h exp=0/0", bus.mem_addr, bus.mem_wdata); else passed++;
        total++; if (hit_cnt !== 4'd0 || miss_cnt !== 4'd0) $display("FAIL reset_cnt got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); else passed++;
    endtask

    task automatic test_read_miss_then_hit();
        int cyc;
        do_reset();
        access(1'b1, 1'b0, 30'h000, 32'd0, cyc);
        total++; if (cyc != 4) $display("FAIL miss_latency got=%0d exp=4", cyc); else passed++;
        total++; if (mlog.size() != 1 || mlog[0].wr !== 1'b0 || mlog[0].addr !== 28'd0)
            $display("FAIL miss_req got=n%0d exp=one read at 0", mlog.size()); else passed++;
        total++; if (hit_cnt !== 4'd0 || miss_cnt !== 4'd1) $display("FAIL miss_cnt got=%0d/%0d exp=0/1", hit_cnt, miss_cnt); else passed++;
        access(1'b1, 1'b0, 30'h002, 32'd0, cyc);
        total++; if (cyc != 0 || mlog.size() != 0) $display("FAIL hit_nomem got=%0d/%0d exp=0/0", cyc, mlog.size()); else passed++;
        total++; if (hit_cnt !== 4'd1) $display("FAIL hit_cnt got=%0d exp=1", hit_cnt); else passed++;
    endtask

    task automatic test_lru_clean();
        int cyc;
        do_reset();
        access(1'b1, 1'b0, mk(1, 0, 0), 32'd0, cyc);
        access(1'b1, 1'b0, mk(2, 0, 1), 32'd0, cyc);
        access(1'b1, 1'b0, mk(1, 0, 2), 32'd0, cyc);
        total++; if (cyc != 0) $display("FAIL lru_hitA got=%0d exp=0", cyc); else passed++;
        access(1'b1, 1'b0, mk(3, 0, 3), 32'd0, cyc);
        total++; if (mlog.size() != 1 || mlog[0].wr !== 1'b0 || mlog[0].addr !== mk(3, 0, 0) >> 2)
            $display("FAIL lru_clean_req got=n%0d exp=one read of C", mlog.size()); else passed++;
        access(1'b1, 1'b0, mk(1, 0, 3), 32'd0, cyc);
        total++; if (cyc != 0) $display("FAIL lru_keepA got=%0d exp=0", cyc); else passed++;
        access(1'b1, 1'b0, mk(2, 0, 0), 32'd0, cyc);
        total++; if (cyc != 4) $display("FAIL lru_evictB got=%0d exp=4", cyc); else passed++;
    endtask

    task automatic test_writeback();
        int cyc;
        do_reset();
        access(1'b1, 1'b0, mk(1, 0, 0), 32'd0, cyc);
        access(1'b0, 1'b1, mk(1, 0, 1), 32'hDEAD_BEEF, cyc);
        total++; if (cyc != 0) $display("FAIL wr_hit got=%0d exp=0", cyc); else passed++;
        access(1'b1, 1'b0, mk(2, 0, 0), 32'd0, cyc);
        access(1'b1, 1'b0, mk(3, 0, 0), 32'd0, cyc);
        total++; if (cyc != 7) $display("FAIL wb_latency got=%0d exp=7", cyc); else passed++;
        total++; if (mlog.size() != 2 || mlog[0].wr !== 1'b1 || mlog[0].addr !== 28'(25'd1 << 3) || mlog[0].data[63:32] !== 32'hDEAD_BEEF)
            $display("FAIL wb_req got=n%0d exp=write {A,0} with DEADBEEF", mlog.size()); else passed++;
        total++; if (mlog.size() != 2 || mlog[1].wr !== 1'b0 || mlog[1].addr !== 28'(25'd3 << 3))
            $display("FAIL wb_refill got=n%0d exp=read {D,0} second", mlog.size()); else passed++;
        access(1'b1, 1'b0, mk(1, 0, 1), 32'd0, cyc);
        access(1'b0, 1'b1, mk(4, 0, 3), 32'hCAFE_F00D, cyc);
        total++; if (cyc != 4) $display("FAIL wr_miss got=%0d exp=4", cyc); else passed++;
        access(1'b1, 1'b0, mk(4, 0, 3), 32'd0, cyc);
        total++; if (hit_cnt !== 4'd2 || miss_cnt !== 4'd5) $display("FAIL wb_cnt got=%0d/%0d exp=2/5", hit_cnt, miss_cnt); else passed++;
    endtask

    task automatic test_reset_midflight();
        int cyc;
        bit seen;
        logic [29:0] x;
        x = mk(9, 3, 1);
        do_reset();
        @(negedge clk);
        bus.proc_read = 1'b1; bus.proc_addr = x;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (bus.mem_read) seen = 1'b1;
            else @(negedge clk);
        end
        total++; if (!seen) $display("FAIL rst_fly_req got=0 exp=1"); else passed++;
        rst = 1'b1;
        #1;
        total++; if (bus.mem_read !== 1'b0 || bus.mem_addr !== 28'd0) $display("FAIL rst_async got=%b/%h exp=0/0", bus.mem_read, bus.mem_addr); else passed++;
        bus.proc_read = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); bus.mem_rdata = '1; bus.mem_ready = 1'b1;
        @(negedge clk); bus.mem_ready = 1'b0;
        #1;
        total++; if (bus.mem_read !== 1'b0 || bus.proc_stall !== 1'b0 || miss_cnt !== 4'd0)
            $display("FAIL rst_stray got=%b%b/%0d exp=00/0", bus.mem_read, bus.proc_stall, miss_cnt); else passed++;
        access(1'b1, 1'b0, x, 32'd0, cyc);
        total++; if (cyc != 4 || mlog.size() != 1 || mlog[0].addr !== x[29:2])
            $display("FAIL rst_remiss got=%0d/n%0d exp=4/1", cyc, mlog.size()); else passed++;
    endtask

    task automatic test_saturation();
        int cyc;
        do_reset();
        access(1'b1, 1'b0, mk(7, 5, 0), 32'd0, cyc);
        for (int i = 0; i < 20; i++) access(1'b1, 1'b0, mk(7, 5, i % 4), 32'd0, cyc);
        total++; if (hit_cnt !== 4'd15 || miss_cnt !== 4'd1) $display("FAIL hit_sat got=%0d/%0d exp=15/1", hit_cnt, miss_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_reset();
        access(1'b1, 1'b0, mk(11, 6, 2), 32'd0, cyc);
        access(1'b1, 1'b1, mk(11, 6, 2), 32'h1234_5678, cyc);
        total++; if (cyc != 0) $display("FAIL rw_both got=%0d exp=0", cyc); else passed++;
        access(1'b1, 1'b0, mk(11, 6, 2), 32'd0, cyc);
        access(1'b1, 1'b0, mk(12, 6, 2), 32'd0, cyc);
        access(1'b1, 1'b0, mk(13, 6, 2), 32'd0, cyc);
        access(1'b1, 1'b0, mk(11, 6, 2), 32'd0, cyc);
        total++; if (both_hi != 0) $display("FAIL rw_exclusive got=%0d exp=0", both_hi); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        bus.proc_read = 1'b0; bus.proc_write = 1'b0; bus.proc_addr = '0; bus.proc_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        test_reset();
        test_read_miss_then_hit();
        test_lru_clean();
        test_writeback();
        test_reset_midflight();
        test_saturation();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
